// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared RV32M encodings and FSM state type for the mul/div unit
package muldiv_pkg;

  localparam logic [6:0] RV32M_FUNCT7 = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  function automatic logic f3_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic f3_op1_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic f3_op2_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - operand/result handshake bundle between execute stage and mul/div unit
interface muldiv_if #(parameter int XLEN = 32);

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output flush, in_valid, funct3, op1, op2, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, funct3, op1, op2, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit; one shared 2*XLEN shift register
// serves radix-2 shift-add multiply and restoring divide on operand magnitudes.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  logic [2:0]        r_f3;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_op2;
  logic              r_neg_res;
  logic              r_neg_rem;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_result;
  logic              r_out_valid;

  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_abs;
  logic [XLEN-1:0]   w_b_abs;
  logic              w_div0;
  logic              w_ovf;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_div_diff;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;

  assign w_a_neg = f3_op1_signed(bus.funct3) & bus.op1[XLEN-1];
  assign w_b_neg = f3_op2_signed(bus.funct3) & bus.op2[XLEN-1];
  assign w_a_abs = w_a_neg ? -bus.op1 : bus.op1;
  assign w_b_abs = w_b_neg ? -bus.op2 : bus.op2;

  // funct3[1] separates REM/REMU from DIV/DIVU among the divide opcodes
  assign w_div0 = f3_is_div(bus.funct3) && (bus.op2 == '0);
  assign w_ovf  = f3_is_div(bus.funct3) && !bus.funct3[0] &&
                  (bus.op1 == MIN_NEG) && (bus.op2 == '1);
  assign w_special_res = w_div0 ? (bus.funct3[1] ? bus.op1 : '1)
                                : (bus.funct3[1] ? '0 : MIN_NEG);

  // Multiply: high half accumulates the multiplicand, low half shifts out multiplier bits
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_op2} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide: partial remainder in the high half, quotient bits shift in from the bottom
  assign w_div_diff = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_op2};
  assign w_div_next = w_div_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                       : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quo  = r_neg_res ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = w_prod[XLEN-1:0];
    if (r_f3[2])
      w_fix_res = r_f3[1] ? w_rem : w_quo;
    else if (r_f3[1:0] != 2'b00)
      w_fix_res = w_prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_f3        <= '0;
      r_acc       <= '0;
      r_op2       <= '0;
      r_neg_res   <= 1'b0;
      r_neg_rem   <= 1'b0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else if (bus.flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_f3      <= bus.funct3;
            r_acc     <= {{XLEN{1'b0}}, w_a_abs};
            r_op2     <= w_b_abs;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_cnt     <= CNT_W'(XLEN);
            if (w_div0 || w_ovf) begin
              r_result <= w_special_res;
              r_state  <= DONE;
            end else begin
              r_state  <= CALC;
            end
          end
        end
        CALC: begin
          r_acc <= r_f3[2] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1))
            r_state <= FIX;
        end
        FIX: begin
          r_result    <= w_fix_res;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          // Special-case results arrive here without out_valid; raise it one edge later
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide execute unit implementing the RV32M funct3 operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the combinational ALU in the execute stage. The decoder routes opcode 0110011 with funct7 0000001 here instead of to the ALU.
- Uses a valid/ready handshake on both input and output, so the core stalls while the unit is busy.

Parameters:
- XLEN, 32, operand/result width; must be even and at least 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous kill of any in-flight operation.
- in_valid  in  1  operands and funct3 are valid.
- in_ready  out  1  unit can accept an operation.
- funct3  in  3  operation select (RV32M encoding).
- op1  in  XLEN  rs1 value.
- op2  in  XLEN  rs2 value.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  operation result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; out_valid=0; result=0; busy=0; in_ready=1.
  - All internal registers are cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge: capture funct3, op1 and op2.
  - For signed operations, store absolute values plus sign flags. MULHSU treats only op1 as signed.
  - Load counter=XLEN, then go to CALC.
- Special cases, detected at capture (next state is DONE directly, result loaded at the same edge):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give op1.
  - Signed overflow (DIV/REM with op1=100..0 and op2=all-ones): DIV gives 100..0; REM gives 0.
- CALC: one iteration per cycle; counter decrements; move to FIX when the counter reaches 1 on this edge, so CALC lasts exactly XLEN cycles.
  - Multiply: radix-2 shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FIX (1 cycle):
  - Apply sign correction by two's-complement negation.
    - Product is negated if the operand signs differ.
    - Quotient is negated if the signs differ.
    - Remainder takes the dividend's sign.
  - Select the output field: MUL takes the low half; MULH/MULHSU/MULHU take the high half; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Register it into result, then go to DONE.
- DONE:
  - out_valid=1.
  - result is held stable while out_ready=0.
  - On out_ready at an edge: out_valid drops and state returns to IDLE.
- Latency:
  - Normal operation: accept at edge T gives out_valid high after edge T+XLEN+1.
  - Special case: out_valid high after edge T+1.
- Throughput:
  - in_ready=0 outside IDLE, so the unit is non-pipelined.
  - A new operation is accepted no earlier than the edge after the result handshake.
- Flush:
  - In any state, the next edge goes to IDLE with out_valid=0; a pending result is discarded.
  - flush and in_valid together in IDLE: the operation is not accepted.
- Reset mid-operation: immediate return to reset values; no partial result appears.
- Arithmetic is modulo 2^XLEN for results; the accumulator is 2*XLEN wide internally; all negation is two's complement.
- X-safety: result is not updated outside FIX and the special-case capture.

Decomposition:
- Shared package (muldiv_pkg):
  - funct3 constants: F3_MUL=000, F3_MULH=001, F3_MULHSU=010, F3_MULHU=011, F3_DIV=100, F3_DIVU=101, F3_REM=110, F3_REMU=111.
  - state enum: IDLE, CALC, FIX, DONE.
  - RV32M funct7 constant: 0000001.
- The decoder imports the same package.
- No sub-module: a single FSM module with shared datapath registers; the multiply and divide iterations share the shift register.

Test Plan:
- MUL op1=7, op2=0xFFFFFFFD -> result 0xFFFFFFEB; out_valid rises after exactly 34 edges from accept (XLEN=32).
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- Special cases, each with out_valid after 2 edges:
  - DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Required: result stable, in_ready=0, in_valid ignored. Then assert out_ready: IDLE on the next edge, and a back-to-back operation is accepted one edge later.
- Flush at CALC cycle 5 -> IDLE next edge; out_valid never asserts. rst_n low mid-CALC -> outputs zero immediately; the next operation MUL 3 x 4 -> 12.
